fetch_unit: RTL and testbench

//  Instruction fetch stage of the Eka core; sits directly upstream of the decoder.

---
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response, execute redirect,
// and the decoder-facing valid/ready instruction port.
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        op_valid;
  logic        ip_ready;
  logic [31:0] op_inst;
  logic [31:0] op_pc;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, op_valid, op_inst, op_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, ip_ready
  );

  // Environment side (memory, execute, decoder)
  modport slave (
    input  imem_req_valid, imem_req_addr, op_valid, op_inst, op_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, ip_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word request outstanding to
// instruction memory, and hands the returned word plus its PC to the decoder.
// A redirect from execute wins over every other event and squashes stale work.
//
// state | meaning
// REQ   | request for pc presented to memory, waiting for acceptance
// WAIT  | request accepted, response still due and wanted
// DROP  | request accepted, response still due but stale (discard it)
// HOLD  | instruction held toward the decoder until consumed or squashed
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic      clk,
  input logic      reset,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        op_valid_q, op_valid_d;
  logic [31:0] op_inst_q, op_inst_d;
  logic [31:0] op_pc_q, op_pc_d;

  logic [31:0] redirect_tgt;

  // Misaligned redirect targets are silently forced onto a word boundary.
  assign redirect_tgt = bus.redirect_pc & ~32'h0000_0003;

  // Next-state, PC and decoder-output computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_valid_d = op_valid_q;
    op_inst_d  = op_inst_q;
    op_pc_d    = op_pc_q;

    case (state_q)
      S_REQ: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt;
          // The old-PC request went out this cycle; its response must be thrown away.
          if (bus.imem_req_ready) state_d = S_DROP;
        end else if (bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
        end else if (bus.imem_resp_valid) begin
          op_inst_d  = bus.imem_resp_data;
          op_pc_d    = pc_q;
          op_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = S_HOLD;
        end
      end
      S_DROP: begin
        if (bus.redirect_valid) pc_d = redirect_tgt;
        // The stale response retires the outstanding request even when a
        // redirect lands in the same cycle; waiting longer would never end.
        if (bus.imem_resp_valid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          op_valid_d = 1'b0;
          pc_d       = redirect_tgt;
          state_d    = S_REQ;
        end else if (bus.ip_ready) begin
          op_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      op_valid_q <= 1'b0;
      op_inst_q  <= NOP_INST;
      op_pc_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_valid_q <= op_valid_d;
      op_inst_q  <= op_inst_d;
      op_pc_q    <= op_pc_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.op_valid       = op_valid_q;
  assign bus.op_inst        = op_inst_q;
  assign bus.op_pc          = op_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if bus_if ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.imem_req_ready  = 1'b0;
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = 32'h0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_pc     = 32'h0;
    bus_if.ip_ready        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // From REQ: request accepted, response next cycle; ends holding the word.
  task automatic fetch_one(input logic [31:0] data);
    bus_if.imem_req_ready = 1'b1;
    tick();
    bus_if.imem_req_ready  = 1'b0;
    bus_if.imem_resp_valid = 1'b1;
    bus_if.imem_resp_data  = data;
    tick();
    bus_if.imem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_if.op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got=%b exp=0", bus_if.op_valid); end
    checks++; if (bus_if.op_inst !== NOP) begin failures++; $display("FAIL reset_op_inst got=%h exp=%h", bus_if.op_inst, NOP); end
    checks++; if (bus_if.op_pc !== 32'h0) begin failures++; $display("FAIL reset_op_pc got=%h exp=0", bus_if.op_pc); end
    checks++; if (bus_if.imem_req_valid !== 1'b1) begin failures++; $display("FAIL reset_req_valid got=%b exp=1", bus_if.imem_req_valid); end
    checks++; if (bus_if.imem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", bus_if.imem_req_addr); end
  endtask

  task automatic test_basic_fetch();
    bus_if.imem_req_ready = 1'b1;
    tick();
    bus_if.imem_req_ready = 1'b0;
    checks++; if (bus_if.imem_req_valid !== 1'b0) begin failures++; $display("FAIL basic_wait_req_valid got=%b exp=0", bus_if.imem_req_valid); end
    bus_if.imem_resp_valid = 1'b1;
    bus_if.imem_resp_data  = 32'h0050_0093;
    tick();
    bus_if.imem_resp_valid = 1'b0;
    checks++; if (bus_if.op_valid !== 1'b1) begin failures++; $display("FAIL basic_op_valid got=%b exp=1", bus_if.op_valid); end
    checks++; if (bus_if.op_inst !== 32'h0050_0093) begin failures++; $display("FAIL basic_op_inst got=%h exp=00500093", bus_if.op_inst); end
    checks++; if (bus_if.op_pc !== 32'h0) begin failures++; $display("FAIL basic_op_pc got=%h exp=0", bus_if.op_pc); end
    bus_if.ip_ready = 1'b1;
    tick();
    bus_if.ip_ready = 1'b0;
    checks++; if (bus_if.op_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed got=%b exp=0", bus_if.op_valid); end
    checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h4) begin failures++; $display("FAIL basic_next_req got=%b/%h exp=1/4", bus_if.imem_req_valid, bus_if.imem_req_addr); end
  endtask

  task automatic test_decoder_stall();
    fetch_one(32'h1111_2222);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus_if.op_valid !== 1'b1 || bus_if.op_inst !== 32'h1111_2222 ||
          bus_if.op_pc !== 32'h4 || bus_if.imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL dec_stall cyc=%0d got v=%b inst=%h pc=%h req=%b exp v=1 inst=11112222 pc=4 req=0",
                 i, bus_if.op_valid, bus_if.op_inst, bus_if.op_pc, bus_if.imem_req_valid);
      end
    end
    bus_if.ip_ready = 1'b1;
    tick();
    bus_if.ip_ready = 1'b0;
    checks++; if (bus_if.imem_req_addr !== 32'h8) begin failures++; $display("FAIL dec_stall_next got=%h exp=8", bus_if.imem_req_addr); end
  endtask

  task automatic test_mem_stall();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h8 || bus_if.op_valid !== 1'b0) begin
        failures++;
        $display("FAIL mem_stall cyc=%0d got req=%b addr=%h v=%b exp req=1 addr=8 v=0",
                 i, bus_if.imem_req_valid, bus_if.imem_req_addr, bus_if.op_valid);
      end
    end
    fetch_one(32'h3333_4444);
    checks++; if (bus_if.op_pc !== 32'h8 || bus_if.op_inst !== 32'h3333_4444) begin failures++; $display("FAIL mem_stall_fetch got pc=%h inst=%h exp pc=8 inst=33334444", bus_if.op_pc, bus_if.op_inst); end
    bus_if.ip_ready = 1'b1;
    tick();
    bus_if.ip_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bus_if.imem_req_ready = 1'b1;
    tick();
    bus_if.imem_req_ready = 1'b0;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0103;
    tick();
    bus_if.redirect_valid = 1'b0;
    tick();
    checks++; if (bus_if.op_valid !== 1'b0 || bus_if.imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_wait_drop got v=%b req=%b exp 0/0", bus_if.op_valid, bus_if.imem_req_valid); end
    bus_if.imem_resp_valid = 1'b1;
    bus_if.imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    bus_if.imem_resp_valid = 1'b0;
    checks++; if (bus_if.op_valid !== 1'b0) begin failures++; $display("FAIL redir_wait_stale got v=%b exp=0", bus_if.op_valid); end
    checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h100) begin failures++; $display("FAIL redir_wait_next got=%b/%h exp=1/100", bus_if.imem_req_valid, bus_if.imem_req_addr); end
  endtask

  task automatic test_redirect_resp();
    bus_if.imem_req_ready = 1'b1;
    tick();
    bus_if.imem_req_ready  = 1'b0;
    bus_if.redirect_valid  = 1'b1;
    bus_if.redirect_pc     = 32'h0000_0200;
    bus_if.imem_resp_valid = 1'b1;
    bus_if.imem_resp_data  = 32'hBAD0_0001;
    tick();
    idle_inputs();
    checks++; if (bus_if.op_valid !== 1'b0) begin failures++; $display("FAIL redir_resp_v got=%b exp=0", bus_if.op_valid); end
    checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h200) begin failures++; $display("FAIL redir_resp_next got=%b/%h exp=1/200", bus_if.imem_req_valid, bus_if.imem_req_addr); end
    fetch_one(32'h5555_6666);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0382;
    bus_if.ip_ready       = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus_if.op_valid !== 1'b0) begin failures++; $display("FAIL redir_hold_v got=%b exp=0", bus_if.op_valid); end
    checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h380) begin failures++; $display("FAIL redir_hold_next got=%b/%h exp=1/380", bus_if.imem_req_valid, bus_if.imem_req_addr); end
  endtask

  task automatic test_wrap_and_reset();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus_if.redirect_valid = 1'b0;
    checks++; if (bus_if.imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_target got=%h exp=fffffffc", bus_if.imem_req_addr); end
    fetch_one(32'h7777_8888);
    checks++; if (bus_if.op_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_op_pc got=%h exp=fffffffc", bus_if.op_pc); end
    bus_if.ip_ready = 1'b1;
    tick();
    bus_if.ip_ready = 1'b0;
    checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", bus_if.imem_req_valid, bus_if.imem_req_addr); end
    fetch_one(32'h9999_AAAA);
    bus_if.ip_ready = 1'b1;
    tick();
    bus_if.ip_ready       = 1'b0;
    bus_if.imem_req_ready = 1'b1;
    tick();
    bus_if.imem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus_if.op_valid !== 1'b0) begin failures++; $display("FAIL midreset_v got=%b exp=0", bus_if.op_valid); end
    checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h0) begin failures++; $display("FAIL midreset_next got=%b/%h exp=1/0", bus_if.imem_req_valid, bus_if.imem_req_addr); end
  endtask

  // Randomized traffic against a transaction-level model: a PC stream,
  // at most one request in flight (possibly marked stale), at most one held word.
  task automatic test_random();
    logic [31:0] m_pc, m_req_pc, m_hold_pc, pend_addr, tgt;
    bit m_inflight, m_stale, m_hold, pend, rdy, rsp, rv, ipr, req_fire, resp_hit, exp_req;
    int pend_delay, delivered;
    do_reset();
    m_pc = 32'h0; m_req_pc = 32'h0; m_hold_pc = 32'h0; pend_addr = 32'h0;
    m_inflight = 0; m_stale = 0; m_hold = 0; pend = 0; pend_delay = 0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_req = !m_inflight && !m_hold;
      checks++;
      if (bus_if.op_valid !== m_hold) begin failures++; $display("FAIL rnd_op_valid cyc=%0d got=%b exp=%b", cyc, bus_if.op_valid, m_hold); end
      checks++;
      if (bus_if.imem_req_valid !== exp_req) begin failures++; $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", cyc, bus_if.imem_req_valid, exp_req); end
      if (exp_req) begin
        checks++;
        if (bus_if.imem_req_addr !== m_pc) begin failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, bus_if.imem_req_addr, m_pc); end
      end
      if (m_hold) begin
        checks++;
        if (bus_if.op_pc !== m_hold_pc || bus_if.op_inst !== mem_word(m_hold_pc)) begin
          failures++;
          $display("FAIL rnd_op cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus_if.op_pc, bus_if.op_inst, m_hold_pc, mem_word(m_hold_pc));
        end
      end

      rsp = 0;
      bus_if.imem_resp_data = $urandom;
      if (pend) begin
        if (pend_delay == 0) begin
          rsp = 1; pend = 0;
          bus_if.imem_resp_data = mem_word(pend_addr);
        end else begin
          pend_delay--;
        end
      end else if ($urandom_range(7) == 0) begin
        rsp = 1;
      end
      rdy = ($urandom_range(2) != 0);
      ipr = $urandom_range(1);
      rv  = !rsp && ($urandom_range(9) == 0);
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      bus_if.imem_resp_valid = rsp;
      bus_if.imem_req_ready  = rdy;
      bus_if.ip_ready        = ipr;
      bus_if.redirect_valid  = rv;
      bus_if.redirect_pc     = tgt;

      req_fire = exp_req && rdy;
      resp_hit = m_inflight && rsp;
      if (req_fire) begin
        pend = 1; pend_delay = $urandom_range(2); pend_addr = bus_if.imem_req_addr;
        m_req_pc = m_pc;
      end
      if (rv) begin
        m_pc = {tgt[31:2], 2'b00};
        m_hold = 0;
        if (req_fire) begin m_inflight = 1; m_stale = 1; end
        else if (resp_hit) m_inflight = 0;
        else if (m_inflight) m_stale = 1;
      end else begin
        if (m_hold && ipr) begin m_hold = 0; delivered++; end
        if (req_fire) begin m_inflight = 1; m_stale = 0; end
        if (resp_hit) begin
          m_inflight = 0;
          if (!m_stale) begin
            m_hold = 1; m_hold_pc = m_req_pc; m_pc = m_req_pc + 32'd4;
          end
        end
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (delivered < 50) begin failures++; $display("FAIL rnd_progress got=%0d exp>=50", delivered); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_decoder_stall();
    test_mem_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
